// File: rtl/ntt_bram_responder.sv
// ntt_bram_responder: word-addressed 64-bit memory behind the NTT BRAM master's
// byte-addressed port. The host loads N coefficients through s_*, the master owns
// the port in RUN, and N write-backs to the output region trigger streaming the
// results out on m_*.
// Build option: define NTT_BRAM_ADDR_CHECK_EN to add the sticky addr_err output.
//
// Stream handshake (s_* and m_*): a beat transfers on the rising clk edge where
// valid && ready are both high. A producer that raises valid holds it, with its
// data stable, until that edge. ready may change freely while valid is low.
module ntt_bram_responder #(
  parameter int N        = 64,
  parameter int DEPTH    = 128,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] BRAM_addr,
  input  logic        BRAM_clk,
  input  logic [63:0] BRAM_din,
  output logic [63:0] BRAM_dout,
  input  logic        BRAM_en,
  input  logic        BRAM_rst,
  input  logic        BRAM_we,
  input  logic        start,
  input  logic        s_valid,
  input  logic [63:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [63:0] m_data,
  input  logic        m_ready,
  output logic        busy,
`ifdef NTT_BRAM_ADDR_CHECK_EN
  output logic        addr_err,
`endif
  output logic [6:0]  wb_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 7;
  localparam logic [31:0] DEPTH_U   = DEPTH;
  localparam logic [31:0] OUT_LO_U  = OUT_BASE;
  localparam logic [31:0] OUT_HI_U  = OUT_BASE + N;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  logic [63:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [CW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]   wb_cnt_q, wb_cnt_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic            rd_pend_q, rd_pend_d;
  logic [63:0]     rd_data_q, rd_data_d;
  logic            m_valid_q, m_valid_d;
  logic [63:0]     m_data_q, m_data_d;
  logic            skid_valid_q, skid_valid_d;
  logic [63:0]     skid_data_q, skid_data_d;
  logic [63:0]     bram_dout_q, bram_dout_d;

  logic [10:0]     word;
  logic [31:0]     word32;
  logic [AW-1:0]   word_idx;
  logic            word_ok;
  logic            word_out;
  logic            bram_act;
  logic            wb_inc;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [63:0]     mem_wdata;
  logic [AW-1:0]   drain_idx;
  logic            pop;
  logic            last_pop;
  logic            rd_issue;
  logic [1:0]      occ;
  logic [1:0]      occ_after_pop;
  logic            unused_inputs;

  // Port address decode: word index, range checks, and whether the port is live.
  assign word      = BRAM_addr[12:2];
  assign word32    = 32'(word);
  assign word_idx  = word[AW-1:0];
  assign word_ok   = word32 < DEPTH_U;
  assign word_out  = (word32 >= OUT_LO_U) && (word32 < OUT_HI_U) && word_ok;
  assign bram_act  = (state_q == S_RUN) && BRAM_en;
  assign wb_inc    = bram_act && BRAM_we && word_out;
  assign drain_idx = AW'(OUT_BASE) + AW'(rd_ptr_q);

  // Drain buffer bookkeeping: output register + skid register + one read in flight.
  assign pop           = m_valid_q && m_ready;
  assign last_pop      = (state_q == S_DRAIN) && pop && (out_cnt_q == CW'(N - 1));
  assign occ           = {1'b0, m_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
  assign occ_after_pop = occ - {1'b0, pop};

  // BRAM_clk is the master's copy of clk; the low address bits only matter for the
  // optional alignment check.
  assign unused_inputs = ^{BRAM_clk, BRAM_addr[1:0]};

  // Top-level sequencing: IDLE -> LOAD -> RUN -> DRAIN -> IDLE.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    wb_cnt_d = wb_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          ld_cnt_d = ld_cnt_q + 7'd1;
          if (ld_cnt_q == CW'(N - 1)) begin
            state_d  = S_RUN;
            wb_cnt_d = '0;
          end
        end
      end
      S_RUN: begin
        // The write that brings the count to N lands and the FSM moves on at the same edge.
        if (wb_inc) begin
          wb_cnt_d = wb_cnt_q + 7'd1;
          if (wb_cnt_q == CW'(N - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d  = S_IDLE;
          wb_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single memory write port: stream loads in LOAD, master writes in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if ((state_q == S_LOAD) && s_valid) begin
      mem_we    = 1'b1;
      mem_waddr = AW'(IN_BASE) + AW'(ld_cnt_q);
      mem_wdata = s_data;
    end else if (bram_act && BRAM_we && word_ok) begin
      mem_we    = 1'b1;
      mem_waddr = word_idx;
      mem_wdata = BRAM_din;
    end
  end

  // Master read data: read-first, zero beyond DEPTH, held outside RUN, BRAM_rst wins.
  always_comb begin
    bram_dout_d = bram_dout_q;
    if (bram_act) bram_dout_d = word_ok ? mem[word_idx] : 64'd0;
    if (BRAM_rst) bram_dout_d = 64'd0;
  end

  // Result streaming: issue reads while fewer than two words are held or in flight,
  // so the skid register absorbs the read that is in flight when m_ready drops.
  always_comb begin
    rd_issue     = 1'b0;
    rd_pend_d    = 1'b0;
    rd_data_d    = rd_data_q;
    rd_ptr_d     = rd_ptr_q;
    out_cnt_d    = out_cnt_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (state_q == S_DRAIN) begin
      rd_issue  = (rd_ptr_q < CW'(N)) && (occ_after_pop < 2'd2);
      rd_pend_d = rd_issue;
      if (rd_issue) begin
        rd_data_d = mem[drain_idx];
        rd_ptr_d  = rd_ptr_q + 7'd1;
      end
      if (pop) out_cnt_d = out_cnt_q + 7'd1;
      if (!m_valid_q || pop) begin
        if (skid_valid_q) begin
          m_valid_d    = 1'b1;
          m_data_d     = skid_data_q;
          skid_valid_d = rd_pend_q;
          skid_data_d  = rd_data_q;
        end else begin
          m_valid_d = rd_pend_q;
          if (rd_pend_q) m_data_d = rd_data_q;
        end
      end else if (rd_pend_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = rd_data_q;
      end
      if (last_pop) begin
        rd_ptr_d     = '0;
        out_cnt_d    = '0;
        rd_pend_d    = 1'b0;
        m_valid_d    = 1'b0;
        skid_valid_d = 1'b0;
      end
    end else begin
      rd_ptr_d     = '0;
      out_cnt_d    = '0;
      m_valid_d    = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // State and datapath registers; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ld_cnt_q     <= '0;
      wb_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      out_cnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      rd_data_q    <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      bram_dout_q  <= '0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      out_cnt_q    <= out_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_data_q    <= rd_data_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      bram_dout_q  <= bram_dout_d;
    end
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef NTT_BRAM_ADDR_CHECK_EN
  logic addr_err_q, addr_err_d;

  // Sticky flag for misaligned or out-of-range accesses while the port is live.
  always_comb begin
    addr_err_d = addr_err_q;
    if (bram_act && ((BRAM_addr[1:0] != 2'b00) || !word_ok)) addr_err_d = 1'b1;
  end

  // Address error register, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= addr_err_d;
  end

  assign addr_err = addr_err_q;
`endif

  assign BRAM_dout = bram_dout_q;
  assign s_ready   = (state_q == S_LOAD);
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign busy      = (state_q != S_IDLE);
  assign wb_cnt    = wb_cnt_q;

endmodule

// File: tb/tb_ntt_bram_responder.sv
// Self-checking bench for ntt_bram_responder: reset values, load, master port
// table, write-back counting, drain under three m_ready patterns, mid-load reset.
module tb_ntt_bram_responder;

  localparam int N = 64;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] BRAM_addr = '0;
  logic [63:0] BRAM_din = '0;
  logic [63:0] BRAM_dout;
  logic        BRAM_en = 1'b0;
  logic        BRAM_rst = 1'b0;
  logic        BRAM_we = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_ready;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_ready = 1'b0;
  logic        busy;
  logic [6:0]  wb_cnt;
`ifdef NTT_BRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  always #5 clk = ~clk;

  ntt_bram_responder dut (
    .clk       (clk),
    .rst       (rst),
    .BRAM_addr (BRAM_addr),
    .BRAM_clk  (clk),
    .BRAM_din  (BRAM_din),
    .BRAM_dout (BRAM_dout),
    .BRAM_en   (BRAM_en),
    .BRAM_rst  (BRAM_rst),
    .BRAM_we   (BRAM_we),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .busy      (busy),
`ifdef NTT_BRAM_ADDR_CHECK_EN
    .addr_err  (addr_err),
`endif
    .wb_cnt    (wb_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout/underflow, expected completion", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load(input int n, input logic [63:0] base, input bit gaps);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = base + 64'(k);
      if (s_valid && s_ready) k++;
    end
    if (k < n) fail_now("load_timeout");
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic bram_cycle(input bit en, input bit we, input bit brst,
                            input logic [12:0] addr, input logic [63:0] din);
    @(negedge clk);
    BRAM_en = en; BRAM_we = we; BRAM_rst = brst; BRAM_addr = addr; BRAM_din = din;
    @(negedge clk);
    BRAM_en = 1'b0; BRAM_we = 1'b0; BRAM_rst = 1'b0;
  endtask

  task automatic master_write(input int word, input logic [63:0] val);
    bram_cycle(1'b1, 1'b1, 1'b0, 13'(word << 2), val);
  endtask

  task automatic bram_read_check(input string name, input int word, input logic [63:0] exp);
    bram_cycle(1'b1, 1'b0, 1'b0, 13'(word << 2), 64'd0);
    check(name, BRAM_dout, exp);
  endtask

  // mode 0: m_ready held high; 1: toggling 1010...; 2: random stalls
  task automatic drain(input int mode);
    int beats = 0;
    int cyc = 0;
    int bubbles = 0;
    bit seen = 1'b0;
    bit stalled = 1'b0;
    logic [63:0] held = '0;
    logic [63:0] e;
    while (beats < N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2) == 1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (stalled) begin
        check("stall_valid", {63'd0, m_valid}, 64'd1);
        check("stall_data", m_data, held);
      end
      if (m_valid) begin
        seen = 1'b1;
        if (m_ready) begin
          if (exp_q.size() == 0) fail_now("sb_underflow");
          else begin
            e = exp_q.pop_front();
            check($sformatf("drain_m%0d_beat%0d", mode, beats), m_data, e);
          end
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = m_data;
        end
      end else begin
        stalled = 1'b0;
        if (seen) bubbles++;
      end
    end
    if (beats < N) fail_now("drain_timeout");
    if (mode == 0) check("drain_bubbles", 64'(bubbles), 64'd0);
    @(negedge clk);
    m_ready = 1'b0;
    check("done_m_valid", {63'd0, m_valid}, 64'd0);
    check("done_busy", {63'd0, busy}, 64'd0);
    check("done_wb_cnt", {57'd0, wb_cnt}, 64'd0);
  endtask

  // ---------------- master port table ----------------
  typedef struct {
    bit          en;
    bit          we;
    bit          brst;
    logic [12:0] addr;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Contents assume the first load wrote mem[i] = i.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 13'h010, 64'h0,    64'd4};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 13'h000, 64'h0,    64'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 13'h0FC, 64'h0,    64'd63};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 13'h014, 64'hAAAA, 64'd5};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 13'h014, 64'h0,    64'hAAAA};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 13'h0FC, 64'h0,    64'hAAAA};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 13'h200, 64'h1234, 64'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 13'h013, 64'h0,    64'd4};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 13'h0FC, 64'h0,    64'd63};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 13'h010, 64'h0,    64'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 13'h020, 64'h0,    64'd8};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 13'h200, 64'h0,    64'd0};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_bram_dout", BRAM_dout, 64'd0);
    check("rst_wb_cnt", {57'd0, wb_cnt}, 64'd0);
`ifdef NTT_BRAM_ADDR_CHECK_EN
    check("rst_addr_err", {63'd0, addr_err}, 64'd0);
`endif
    rst = 1'b0;

    // ---- transform 1: full-rate drain ----
    pulse_start();
    check("t1_load_busy", {63'd0, busy}, 64'd1);
    check("t1_load_s_ready", {63'd0, s_ready}, 64'd1);
    load(N, 64'd0, 1'b0);
    check("t1_run_s_ready", {63'd0, s_ready}, 64'd0);
    check("t1_run_busy", {63'd0, busy}, 64'd1);
    check("t1_run_wb_cnt", {57'd0, wb_cnt}, 64'd0);

`ifdef NTT_BRAM_ADDR_CHECK_EN
    check("addr_err_clear", {63'd0, addr_err}, 64'd0);
`endif
    bram_cycle(1'b1, 1'b0, 1'b0, 13'h102, 64'd0);
`ifdef NTT_BRAM_ADDR_CHECK_EN
    check("addr_err_set", {63'd0, addr_err}, 64'd1);
`endif

    for (int i = 0; i < 12; i++) begin
      bram_cycle(tbl[i].en, tbl[i].we, tbl[i].brst, tbl[i].addr, tbl[i].din);
      check($sformatf("tbl%0d_dout", i), BRAM_dout, tbl[i].exp);
    end
    check("t1_wb_after_tbl", {57'd0, wb_cnt}, 64'd0);

    // start and s_valid outside their states are ignored
    @(negedge clk); start = 1'b1; s_valid = 1'b1;
    @(negedge clk); start = 1'b0; s_valid = 1'b0;
    check("t1_ign_s_ready", {63'd0, s_ready}, 64'd0);
    check("t1_ign_busy", {63'd0, busy}, 64'd1);

    for (int i = 0; i < N; i++) begin
      exp_q.push_back(64'(i * 3));
      if (i == N - 1) check("t1_wb_63", {57'd0, wb_cnt}, 64'd63);
      master_write(64 + i, 64'(i * 3));
    end
    check("t1_wb_64", {57'd0, wb_cnt}, 64'd64);
    check("t1_drain_busy", {63'd0, busy}, 64'd1);
    drain(0);

    // port outside RUN: BRAM_rst still clears, reads/writes do nothing
    bram_cycle(1'b1, 1'b0, 1'b1, 13'h0FC, 64'd0);
    check("idle_bram_rst", BRAM_dout, 64'd0);
    bram_cycle(1'b1, 1'b0, 1'b0, 13'h0FC, 64'd0);
    check("idle_read_hold", BRAM_dout, 64'd0);
    bram_cycle(1'b1, 1'b1, 1'b0, 13'h100, 64'h5555);
    check("idle_write_hold", BRAM_dout, 64'd0);
`ifdef NTT_BRAM_ADDR_CHECK_EN
    check("addr_err_sticky", {63'd0, addr_err}, 64'd1);
`endif

    // ---- transform 2: reset mid-load, reload with gaps, repeat write, random stalls ----
    pulse_start();
    load(20, 64'h100, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_wb_cnt", {57'd0, wb_cnt}, 64'd0);
`ifdef NTT_BRAM_ADDR_CHECK_EN
    check("mid_rst_addr_err", {63'd0, addr_err}, 64'd0);
`endif

    // a master write held throughout LOAD must be dropped
    BRAM_en = 1'b1; BRAM_we = 1'b1; BRAM_addr = 13'h100; BRAM_din = 64'hDEAD;
    pulse_start();
    load(N, 64'h100, 1'b1);
    BRAM_en = 1'b0; BRAM_we = 1'b0;
    check("t2_wb_load_drop", {57'd0, wb_cnt}, 64'd0);
    bram_read_check("t2_rd_w0", 0, 64'h100);
    bram_read_check("t2_rd_w19", 19, 64'h113);
    bram_read_check("t2_rd_w20", 20, 64'h114);
    bram_read_check("t2_rd_w63", 63, 64'h13F);
    bram_read_check("t2_rd_w64", 64, 64'd0);
    bram_read_check("t2_rd_w2047", 2047, 64'd0);

    exp_q.push_back(64'hBEEF);
    for (int i = 1; i < N - 1; i++) exp_q.push_back(64'(i * 5 + 7));
    exp_q.push_back(64'd189);
    for (int i = 0; i < N - 1; i++) master_write(64 + i, 64'(i * 5 + 7));
    check("t2_wb_63", {57'd0, wb_cnt}, 64'd63);
    master_write(64, 64'hBEEF);
    check("t2_wb_64", {57'd0, wb_cnt}, 64'd64);
    drain(2);

    // ---- transform 3: toggling m_ready ----
    pulse_start();
    load(N, 64'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(64'(i * 3 + 1));
      master_write(64 + i, 64'(i * 3 + 1));
    end
    drain(1);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
